// File: rtl/gpio_scan_sequencer.sv
// gpio_scan_sequencer: routes a square-wave test tone to one GPIO channel at a time (auto/manual stepping).
// Buttons are synchronised and debounced; only debounced press edges drive the mode/channel FSM.
module gpio_scan_sequencer #(
    parameter int NUM_CH       = 26,
    parameter int IDX_W        = 5,
    parameter int DWELL_CYCLES = 25000000,
    parameter int TONE_HALF    = 12,
    parameter int DEB_CYCLES   = 250000
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_next,
    output logic [NUM_CH-1:0] ch_out,
    output logic [IDX_W-1:0]  ch_idx,
    output logic [1:0]        mode,
    output logic              tone
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] AUTO   = 2'd1;
    localparam logic [1:0] MANUAL = 2'd2;
    localparam logic [1:0] ALL    = 2'd3;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int TONE_W  = $clog2(TONE_HALF + 1);

    logic [1:0] btn;
    logic [1:0] press;
    assign btn = {btn_next, btn_mode};

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_deb
            logic             s1;
            logic             s2;
            logic             stable;
            logic [DEB_W-1:0] cnt;
            logic             hit;
            assign hit      = (s2 != stable) && (cnt == DEB_W'(DEB_CYCLES - 1));
            // press fires on the accepting edge itself so the FSM sees it in the same cycle
            assign press[b] = hit & s2;
            always_ff @(posedge clk_25mhz or negedge rst_n) begin
                if (!rst_n) begin
                    s1     <= 1'b0;
                    s2     <= 1'b0;
                    stable <= 1'b0;
                    cnt    <= '0;
                end else begin
                    s1     <= btn[b];
                    s2     <= s1;
                    stable <= hit ? s2 : stable;
                    cnt    <= (s2 == stable || hit) ? '0 : cnt + DEB_W'(1);
                end
            end
        end
    endgenerate

    logic [TONE_W-1:0] tone_cnt;
    logic              tone_wrap;
    assign tone_wrap = tone_cnt == TONE_W'(TONE_HALF - 1);

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else begin
            tone_cnt <= tone_wrap ? '0 : tone_cnt + TONE_W'(1);
            tone     <= tone ^ tone_wrap;
        end
    end

    logic [DWELL_W-1:0] dwell;
    logic [IDX_W-1:0]   adv_idx;
    logic               dwell_end;
    logic [NUM_CH-1:0]  sel;
    assign adv_idx   = (ch_idx == IDX_W'(NUM_CH - 1)) ? '0 : ch_idx + IDX_W'(1);
    assign dwell_end = dwell == DWELL_W'(DWELL_CYCLES - 1);
    assign sel       = NUM_CH'(1) << ch_idx;

    // mode press takes priority, so a coincident next press is dropped
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= IDLE;
            ch_idx <= '0;
            dwell  <= '0;
        end else if (press[0]) begin
            mode   <= mode + 2'd1;
            ch_idx <= '0;
            dwell  <= '0;
        end else if (mode == AUTO) begin
            ch_idx <= (press[1] || dwell_end) ? adv_idx : ch_idx;
            dwell  <= (press[1] || dwell_end) ? '0 : dwell + DWELL_W'(1);
        end else if (mode == MANUAL) begin
            ch_idx <= press[1] ? adv_idx : ch_idx;
            dwell  <= '0;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) ch_out <= '0;
        else ch_out <= (mode == ALL) ? {NUM_CH{tone}} : (mode != IDLE && tone) ? sel : '0;
    end
endmodule
